// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding (also used by
// the decoder) and the FSM state type.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } mdu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_calc.sv
// Combinational HI/LO result for a latched mult/div, including the
// divide-by-zero (HI/LO kept) and signed-overflow rules.
module mdu_calc
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  mdu_op_e          op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int W = WIDTH;

    logic signed [2*W-1:0] prod_s;
    logic        [2*W-1:0] prod_u;
    logic                  neg_a, neg_b, b_zero, ovf, is_div;
    logic        [W-1:0]   mag_a, mag_b, dvd, dsr, quo, rem;

    assign prod_s = $signed({{W{a_i[W-1]}}, a_i}) * $signed({{W{b_i[W-1]}}, b_i});
    assign prod_u = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};

    // Signed division runs on magnitudes through the same unsigned divider.
    assign neg_a  = a_i[W-1];
    assign neg_b  = b_i[W-1];
    assign mag_a  = neg_a ? (~a_i + 1'b1) : a_i;
    assign mag_b  = neg_b ? (~b_i + 1'b1) : b_i;
    assign is_div = (op_i == OP_DIV);
    assign b_zero = (b_i == '0);
    assign ovf    = is_div && (a_i == {1'b1, {(W-1){1'b0}}}) && (b_i == '1);
    assign dvd    = is_div ? mag_a : a_i;
    assign dsr    = b_zero ? {{(W-1){1'b0}}, 1'b1} : (is_div ? mag_b : b_i);
    assign quo    = dvd / dsr;
    assign rem    = dvd % dsr;

    always_comb begin
        hi_o = hi_i;
        lo_o = lo_i;
        case (op_i)
            OP_MULT:  {hi_o, lo_o} = $unsigned(prod_s);
            OP_MULTU: {hi_o, lo_o} = prod_u;
            OP_DIV: begin
                if (ovf) begin
                    lo_o = a_i;
                    hi_o = '0;
                end else if (!b_zero) begin
                    lo_o = (neg_a ^ neg_b) ? (~quo + 1'b1) : quo;
                    hi_o = neg_a ? (~rem + 1'b1) : rem;
                end
            end
            OP_DIVU: begin
                if (!b_zero) begin
                    lo_o = quo;
                    hi_o = rem;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO: issue FSM,
// busy down-counter, operand latches and HI/LO registers.
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             kill,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    mdu_op_e          op_q, op_d, op_in;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] calc_hi, calc_lo;
    logic             accept;

    assign op_in  = mdu_op_e'(op);
    assign accept = start && !kill && !busy_q && (op_in != OP_NONE);

    mdu_calc #(.WIDTH(WIDTH)) u_calc (
        .op_i (op_q),
        .a_i  (a_q),
        .b_i  (b_q),
        .hi_i (hi_q),
        .lo_i (lo_q),
        .hi_o (calc_hi),
        .lo_o (calc_lo)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (op_in)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            state_d = S_RUN;
                            busy_d  = 1'b1;
                            op_d    = op_in;
                            a_d     = a;
                            b_d     = b;
                            cnt_d   = (op_in == OP_MULT || op_in == OP_MULTU)
                                      ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Commit on the edge where the counter leaves 1.
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = calc_hi;
                    lo_d    = calc_lo;
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Operand latches carry data only and need no reset.
    always_ff @(posedge clk) begin
        op_q <= op_d;
        a_q  <= a_d;
        b_q  <= b_d;
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: hand-computed HI/LO results, busy lengths,
// kill/busy-ignore behaviour and mid-operation reset.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic        kill = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;

    mdu #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .kill  (kill),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a request for one edge; returns at the following negedge.
    task automatic issue(input mdu_op_e o, input logic [31:0] av, input logic [31:0] bv,
                         input logic k);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        kill  = k;
        @(negedge clk);
        start = 1'b0;
        op    = OP_NONE;
        kill  = 1'b0;
    endtask

    // Counts busy cycles from the current negedge until busy drops (bounded).
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_hi", hi, 32'd0);
        check_eq("rst_lo", lo, 32'd0);

        issue(OP_MULT, 32'hFFFF_FFFF, 32'h2, 1'b0);
        wait_idle(cyc);
        check_eq("mult_busy", cyc, 32'd5);
        check_eq("mult_hi", hi, 32'hFFFF_FFFF);
        check_eq("mult_lo", lo, 32'hFFFF_FFFE);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'h2, 1'b0);
        wait_idle(cyc);
        check_eq("multu_busy", cyc, 32'd5);
        check_eq("multu_hi", hi, 32'h0000_0001);
        check_eq("multu_lo", lo, 32'hFFFF_FFFE);

        issue(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
        wait_idle(cyc);
        check_eq("mult_neg_hi", hi, 32'hFFFF_FFFF);
        check_eq("mult_neg_lo", lo, 32'hFFFF_FFF1);

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_idle(cyc);
        check_eq("div_busy", cyc, 32'd10);
        check_eq("div_lo", lo, 32'hFFFF_FFFD);
        check_eq("div_hi", hi, 32'hFFFF_FFFF);

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_idle(cyc);
        check_eq("div_ovf_busy", cyc, 32'd10);
        check_eq("div_ovf_lo", lo, 32'h8000_0000);
        check_eq("div_ovf_hi", hi, 32'h0000_0000);

        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);
        wait_idle(cyc);
        check_eq("div_negb_lo", lo, 32'hFFFF_FFFD);
        check_eq("div_negb_hi", hi, 32'h0000_0001);

        issue(OP_DIVU, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_idle(cyc);
        check_eq("divu_lo", lo, 32'h7FFF_FFFC);
        check_eq("divu_hi", hi, 32'h0000_0001);

        issue(OP_MTHI, 32'h1234, 32'd0, 1'b0);
        check_eq("mthi_busy", {31'd0, busy}, 32'd0);
        check_eq("mthi_hi", hi, 32'h0000_1234);
        check_eq("mthi_lo_kept", lo, 32'h7FFF_FFFC);

        issue(OP_DIVU, 32'd7, 32'd0, 1'b0);
        wait_idle(cyc);
        check_eq("divz_busy", cyc, 32'd10);
        check_eq("divz_hi", hi, 32'h0000_1234);
        check_eq("divz_lo", lo, 32'h7FFF_FFFC);

        issue(OP_MULT, 32'd3, 32'd4, 1'b1);
        check_eq("kill_busy", {31'd0, busy}, 32'd0);
        repeat (6) @(negedge clk);
        check_eq("kill_hi", hi, 32'h0000_1234);
        check_eq("kill_lo", lo, 32'h7FFF_FFFC);

        issue(OP_MTLO, 32'h55, 32'd0, 1'b0);
        check_eq("mtlo_lo", lo, 32'h0000_0055);

        issue(OP_MULT, 32'd3, 32'd4, 1'b0);
        issue(OP_MTLO, 32'hAA, 32'd0, 1'b0);
        check_eq("mtlo_busy_ign", lo, 32'h0000_0055);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_idle(cyc);
        check_eq("busy_rest", cyc, 32'd3);
        check_eq("busy_ign_hi", hi, 32'h0000_0000);
        check_eq("busy_ign_lo", lo, 32'h0000_000C);

        issue(OP_DIV, 32'd100, 32'd7, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        check_eq("midrst_hi", hi, 32'd0);
        check_eq("midrst_lo", lo, 32'd0);
        repeat (12) @(negedge clk);
        check_eq("midrst_late_hi", hi, 32'd0);
        check_eq("midrst_late_lo", lo, 32'd0);
        check_eq("midrst_late_busy", {31'd0, busy}, 32'd0);

        reset = 1'b1;
        issue(OP_MTHI, 32'hBEEF, 32'd0, 1'b0);
        reset = 1'b0;
        check_eq("rst_prio_hi", hi, 32'd0);
        check_eq("rst_prio_busy", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
